// File: rtl/clock_divider_multi.sv
// clock_divider_multi
// Multi-channel divider of the system clock. Each channel produces a 50%-duty
// divided clock, a one-cycle tick on every rising transition of that clock and
// a flag showing that a newly written half-period is waiting to take effect.
// A written half-period is only taken over at the end of a half-period (wrap)
// or on a sync pulse, so a reload can never shorten a phase already under way.
module clock_divider_multi #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int OUT_FREQ = 1,
   parameter int NUM_CH   = 2,
   parameter int CNT_W    = 26,
   parameter int CH_W     = 1
) (
   input  logic              clk_50MHz,
   input  logic              set,
   input  logic [NUM_CH-1:0] en,
   input  logic              sync,
   input  logic              load,
   input  logic [CH_W-1:0]   load_ch,
   input  logic [CNT_W-1:0]  div_val,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] upd_pend
);

   // Half-period (in cycles minus one) that gives OUT_FREQ after reset.
   localparam logic [CNT_W-1:0] HP_DEFAULT = CNT_W'(CLK_FREQ / (2 * OUT_FREQ) - 1);

   // Per-channel state: running counter, the half-period in use and the
   // half-period written by software but not yet taken over.
   logic [CNT_W-1:0] cnt     [NUM_CH];
   logic [CNT_W-1:0] hp_act  [NUM_CH];
   logic [CNT_W-1:0] hp_pend [NUM_CH];

   // One-hot channel select for the load strobe. load is a plain write
   // strobe with no back-pressure: it is accepted on every edge it is high,
   // and a channel number with no matching channel selects nothing.
   logic [NUM_CH-1:0] load_sel;

   // Decode load_ch into a per-channel write enable.
   always_comb begin
      load_sel = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (load && (int'(load_ch) == i)) begin
            load_sel[i] = 1'b1;
         end
      end
   end

   // Channel counters, outputs and half-period registers; priority set > sync > count.
   always_ff @(posedge clk_50MHz) begin
      if (set) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt[i]      <= '0;
            hp_act[i]   <= HP_DEFAULT;
            hp_pend[i]  <= HP_DEFAULT;
            clk_out[i]  <= 1'b0;
            tick[i]     <= 1'b0;
            upd_pend[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            tick[i] <= 1'b0;
            if (sync) begin
               // Phase-align every channel, enabled or not, and take over the
               // pending half-period as it stood before this edge.
               cnt[i]      <= '0;
               clk_out[i]  <= 1'b0;
               hp_act[i]   <= hp_pend[i];
               upd_pend[i] <= 1'b0;
            end else if (en[i]) begin
               if (cnt[i] == hp_act[i]) begin
                  // End of a half-period: toggle and pick up the pending value.
                  cnt[i]      <= '0;
                  clk_out[i]  <= ~clk_out[i];
                  tick[i]     <= ~clk_out[i];
                  hp_act[i]   <= hp_pend[i];
                  upd_pend[i] <= 1'b0;
               end else begin
                  cnt[i] <= cnt[i] + 1'b1;
               end
            end
            // A write on the same edge as a wrap or sync lands after them, so
            // the new value stays pending until the next wrap or sync.
            if (load_sel[i]) begin
               hp_pend[i]  <= div_val;
               upd_pend[i] <= 1'b1;
            end
         end
      end
   end

endmodule
